// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 (800x525 total).
package vga_timing_pkg;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF =
      H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF =
      V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam bit SYNC_ACT_LOW  = 1'b0;
   localparam bit SYNC_ACT_HIGH = 1'b1;

   function automatic int calc_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Control inputs and raster outputs of vga_timing_gen.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if
   import vga_timing_pkg::*;
#(
   parameter int HW = calc_width(H_TOTAL_DEF),
   parameter int VW = calc_width(V_TOTAL_DEF)
);

   logic          ena;
   logic          resync;
   logic          pix_stb;
   logic [HW-1:0] hpos;
   logic [VW-1:0] vpos;
   logic          hsync;
   logic          vsync;
   logic          display_on;
   logic          line_start;
   logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   modport master (
      input  ena, resync,
      output pix_stb, hpos, vpos,
      output hsync, vsync, display_on,
      output line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
      , output frame_cnt
`endif
   );

   modport slave (
      output ena, resync,
      input  pix_stb, hpos, vpos,
      input  hsync, vsync, display_on,
      input  line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
      , input frame_cnt
`endif
   );

endinterface

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: tick is high on the terminal count of 0..CLK_DIV-1.
// The count only advances while ena is high.
module vga_pix_div #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output logic tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (ena) begin
         if (cnt_q == TERM) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with genlock resync.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY  = H_DISPLAY_DEF,
   parameter int H_FRONT    = H_FRONT_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BACK     = H_BACK_DEF,
   parameter int V_DISPLAY  = V_DISPLAY_DEF,
   parameter int V_FRONT    = V_FRONT_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BACK     = V_BACK_DEF,
   parameter bit H_SYNC_POL = SYNC_ACT_LOW,
   parameter bit V_SYNC_POL = SYNC_ACT_LOW,
   parameter int CLK_DIV    = 1
) (
   input logic          clk,
   input logic          rst,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HW = calc_width(H_TOTAL);
   localparam int VW = calc_width(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_DISPLAY);
   localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_DISPLAY);
   localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FRONT + V_SYNC);

   if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
       CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: timing segment is 0 or CLK_DIV < 1");
   end

   logic tick;

   vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .ena  (vga.ena),
      .tick (tick)
   );

   logic [HW-1:0] hpos_q, hpos_d;
   logic [VW-1:0] vpos_q, vpos_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic display_on_q, display_on_d;
   logic pix_stb_q, pix_stb_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic pend_q, pend_d;

   // Decodes use the next-state position so they line up with hpos/vpos.
   always_comb begin
      hpos_d        = hpos_q;
      vpos_d        = vpos_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      display_on_d  = display_on_q;
      pix_stb_d     = tick;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      pend_d        = pend_q | vga.resync;
      if (tick) begin
         if (pend_d) begin
            hpos_d = '0;
            vpos_d = '0;
            pend_d = 1'b0;
         end else if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + VW'(1);
         end else begin
            hpos_d = hpos_q + HW'(1);
         end
         hsync_d = (hpos_d >= HS_BEG && hpos_d < HS_END) ?
                   H_SYNC_POL : ~H_SYNC_POL;
         vsync_d = (vpos_d >= VS_BEG && vpos_d < VS_END) ?
                   V_SYNC_POL : ~V_SYNC_POL;
         display_on_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
         line_start_d  = (hpos_d == '0);
         frame_start_d = (hpos_d == '0) && (vpos_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hpos_q        <= '0;
         vpos_q        <= '0;
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         display_on_q  <= 1'b0;
         pix_stb_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         pend_q        <= 1'b0;
      end else begin
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         pix_stb_q     <= pix_stb_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         pend_q        <= pend_d;
      end
   end

   assign vga.pix_stb     = pix_stb_q;
   assign vga.hpos        = hpos_q;
   assign vga.vpos        = vpos_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.display_on  = display_on_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end

   assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations against a frame-position model.
// Define VGA_FRAME_CNT_EN to also check frame_cnt.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int N = 3;
   localparam int C_HD [N] = '{640, 20, 1};
   localparam int C_HF [N] = '{16, 3, 1};
   localparam int C_HS [N] = '{96, 5, 1};
   localparam int C_HB [N] = '{48, 4, 1};
   localparam int C_VD [N] = '{480, 10, 1};
   localparam int C_VF [N] = '{10, 2, 1};
   localparam int C_VS [N] = '{2, 3, 1};
   localparam int C_VB [N] = '{33, 5, 1};
   localparam int C_HT [N] = '{800, 32, 4};
   localparam int C_VT [N] = '{525, 20, 4};
   localparam int C_DIV[N] = '{1, 2, 1};
   localparam int C_HP [N] = '{0, 0, 1};
   localparam int C_VP [N] = '{0, 0, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst[N] = '{1'b1, 1'b1, 1'b1};
   logic ena[N] = '{1'b1, 1'b1, 1'b1};
   logic rsy[N] = '{1'b0, 1'b0, 1'b0};
   logic o_stb[N], o_ls[N], o_fs[N], o_hs[N], o_vs[N], o_de[N];
   logic [15:0] o_h[N], o_v[N];
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] o_fc[N];
`endif
   int checks = 0;
   int failures = 0;

   vga_timing_if #(.HW(calc_width(800)), .VW(calc_width(525))) if0 ();
   vga_timing_if #(.HW(calc_width(32)), .VW(calc_width(20))) if1 ();
   vga_timing_if #(.HW(calc_width(4)), .VW(calc_width(4))) if2 ();

   vga_timing_gen u_dut0 (.clk(clk), .rst(rst[0]), .vga(if0));

   vga_timing_gen #(
      .H_DISPLAY(C_HD[1]), .H_FRONT(C_HF[1]), .H_SYNC(C_HS[1]), .H_BACK(C_HB[1]),
      .V_DISPLAY(C_VD[1]), .V_FRONT(C_VF[1]), .V_SYNC(C_VS[1]), .V_BACK(C_VB[1]),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(C_DIV[1])
   ) u_dut1 (.clk(clk), .rst(rst[1]), .vga(if1));

   vga_timing_gen #(
      .H_DISPLAY(C_HD[2]), .H_FRONT(C_HF[2]), .H_SYNC(C_HS[2]), .H_BACK(C_HB[2]),
      .V_DISPLAY(C_VD[2]), .V_FRONT(C_VF[2]), .V_SYNC(C_VS[2]), .V_BACK(C_VB[2]),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(C_DIV[2])
   ) u_dut2 (.clk(clk), .rst(rst[2]), .vga(if2));

   assign if0.ena = ena[0];
   assign if0.resync = rsy[0];
   assign if1.ena = ena[1];
   assign if1.resync = rsy[1];
   assign if2.ena = ena[2];
   assign if2.resync = rsy[2];

   assign o_stb[0] = if0.pix_stb;
   assign o_ls[0] = if0.line_start;
   assign o_fs[0] = if0.frame_start;
   assign o_hs[0] = if0.hsync;
   assign o_vs[0] = if0.vsync;
   assign o_de[0] = if0.display_on;
   assign o_h[0] = 16'(if0.hpos);
   assign o_v[0] = 16'(if0.vpos);
   assign o_stb[1] = if1.pix_stb;
   assign o_ls[1] = if1.line_start;
   assign o_fs[1] = if1.frame_start;
   assign o_hs[1] = if1.hsync;
   assign o_vs[1] = if1.vsync;
   assign o_de[1] = if1.display_on;
   assign o_h[1] = 16'(if1.hpos);
   assign o_v[1] = 16'(if1.vpos);
   assign o_stb[2] = if2.pix_stb;
   assign o_ls[2] = if2.line_start;
   assign o_fs[2] = if2.frame_start;
   assign o_hs[2] = if2.hsync;
   assign o_vs[2] = if2.vsync;
   assign o_de[2] = if2.display_on;
   assign o_h[2] = 16'(if2.hpos);
   assign o_v[2] = 16'(if2.vpos);
`ifdef VGA_FRAME_CNT_EN
   assign o_fc[0] = if0.frame_cnt;
   assign o_fc[1] = if1.frame_cnt;
   assign o_fc[2] = if2.frame_cnt;
`endif

   // Model: linear pixel index within the frame plus clocks into the pixel period.
   int m_p[N], m_c[N], m_fc[N];
   bit m_pend[N], m_on[N], m_stb[N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst[i]) begin
            m_p[i] = 0;
            m_c[i] = 0;
            m_fc[i] = 0;
            m_pend[i] = 0;
            m_on[i] = 0;
            m_stb[i] = 0;
         end else begin
            m_stb[i] = 0;
            if (rsy[i]) m_pend[i] = 1;
            if (ena[i]) begin
               m_c[i] = m_c[i] + 1;
               if (m_c[i] == C_DIV[i]) begin
                  m_c[i] = 0;
                  m_stb[i] = 1;
                  m_on[i] = 1;
                  if (m_pend[i]) begin
                     m_p[i] = 0;
                     m_pend[i] = 0;
                  end else begin
                     m_p[i] = (m_p[i] + 1) % (C_HT[i] * C_VT[i]);
                  end
                  if (m_p[i] == 0) m_fc[i] = (m_fc[i] + 1) % 65536;
               end
            end
         end
      end
   end

   function automatic logic [37:0] expv(input int i);
      int h, v;
      bit hs, vs, de, hp, vp;
      h = m_p[i] % C_HT[i];
      v = m_p[i] / C_HT[i];
      hp = (C_HP[i] != 0);
      vp = (C_VP[i] != 0);
      hs = m_on[i] && h >= C_HD[i] + C_HF[i] && h < C_HD[i] + C_HF[i] + C_HS[i];
      vs = m_on[i] && v >= C_VD[i] + C_VF[i] && v < C_VD[i] + C_VF[i] + C_VS[i];
      de = m_on[i] && h < C_HD[i] && v < C_VD[i];
      return {m_stb[i], m_stb[i] && h == 0, m_stb[i] && m_p[i] == 0,
              hs ? hp : !hp, vs ? vp : !vp, de, 16'(h), 16'(v)};
   endfunction

   always @(negedge clk) begin
      logic [37:0] e, a;
      for (int i = 0; i < N; i++) begin
         e = expv(i);
         a = {o_stb[i], o_ls[i], o_fs[i], o_hs[i], o_vs[i], o_de[i], o_h[i], o_v[i]};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL model_dut%0d t=%0t stb/ls/fs/hs/vs/de got %b want %b hpos got %0d want %0d vpos got %0d want %0d",
                     i, $time, a[37:32], e[37:32], a[31:16], e[31:16], a[15:0], e[15:0]);
         end
`ifdef VGA_FRAME_CNT_EN
         checks++;
         if (o_fc[i] !== 16'(m_fc[i])) begin
            failures++;
            $display("FAIL model_fcnt_dut%0d t=%0t got %0d want %0d", i, $time, o_fc[i], m_fc[i]);
         end
`endif
      end
   end

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
      end
   endtask

   task automatic wait_at(input int i, input int h, input int v, input int lim, output bit ok);
      ok = 0;
      for (int k = 0; k < lim && !ok; k++) begin
         @(negedge clk);
         ok = o_stb[i] && (h < 0 || int'(o_h[i]) == h) && (v < 0 || int'(o_v[i]) == v);
      end
      if (!ok) chk($sformatf("wait_timeout_dut%0d", i), 0, 1);
   endtask

   // Stats over strobes from one line/frame marker to the next.
   task automatic measure(input int i, input bit line, output int clks, output int hs_n,
                          output int vs_n, output int de_n, output int hs_h, output int vs_v);
      int lim;
      bit go;
      clks = 0; hs_n = 0; vs_n = 0; de_n = 0; hs_h = -1; vs_v = -1;
      lim = line ? 4 * C_HT[i] * C_DIV[i] : 4 * C_HT[i] * C_VT[i] * C_DIV[i];
      go = 0;
      for (int k = 0; k < lim && !go; k++) begin
         @(negedge clk);
         go = line ? o_ls[i] : o_fs[i];
      end
      if (!go) begin
         chk($sformatf("marker_timeout_dut%0d", i), 0, 1);
         return;
      end
      do begin
         if (o_stb[i]) begin
            if (o_hs[i] == 1'(C_HP[i])) begin
               hs_n++;
               if (hs_h < 0) hs_h = int'(o_h[i]);
            end
            if (o_vs[i] == 1'(C_VP[i])) begin
               vs_n++;
               if (vs_v < 0) vs_v = int'(o_v[i]);
            end
            if (o_de[i]) de_n++;
         end
         @(negedge clk);
         clks++;
      end while (!(line ? o_ls[i] : o_fs[i]) && clks < lim);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int clks, hs_n, vs_n, de_n, hs_h, vs_v, pulses;
      bit ok;
      repeat (3) @(negedge clk);
      chk("rst_hpos0", o_h[0], 0);
      chk("rst_vpos0", o_v[0], 0);
      chk("rst_hsync0", o_hs[0], 1);
      chk("rst_vsync0", o_vs[0], 1);
      chk("rst_de0", o_de[0], 0);
      chk("rst_stb0", o_stb[0], 0);
      chk("rst_hsync2_pol1", o_hs[2], 0);
      chk("rst_vsync2_pol1", o_vs[2], 0);
      #1;
      for (int i = 0; i < N; i++) rst[i] = 0;
      @(negedge clk);
      chk("first_stb0", o_stb[0], 1);
      chk("first_hpos0", o_h[0], 1);
      chk("first_de0", o_de[0], 1);
      chk("first_stb1_div2", o_stb[1], 0);
      chk("first_hpos1_div2", o_h[1], 0);

      measure(0, 1, clks, hs_n, vs_n, de_n, hs_h, vs_v);
      chk("line_clks0", clks, 800);
      chk("line_hsync_n0", hs_n, 96);
      chk("line_hsync_first0", hs_h, 656);
      chk("line_de_n0", de_n, 640);
      chk("line_vsync_n0", vs_n, 0);

      measure(1, 0, clks, hs_n, vs_n, de_n, hs_h, vs_v);
      chk("frame_clks1", clks, 1280);
      chk("frame_hsync_n1", hs_n, 100);
      chk("frame_hsync_first1", hs_h, 23);
      chk("frame_vsync_n1", vs_n, 96);
      chk("frame_vsync_first1", vs_v, 12);
      chk("frame_de_n1", de_n, 200);

      measure(2, 0, clks, hs_n, vs_n, de_n, hs_h, vs_v);
      chk("frame_clks2", clks, 16);
      chk("frame_hsync_n2", hs_n, 4);
      chk("frame_hsync_first2", hs_h, 2);
      chk("frame_vsync_n2", vs_n, 4);
      chk("frame_vsync_first2", vs_v, 2);
      chk("frame_de_n2", de_n, 1);

      wait_at(1, 10, 3, 1400, ok);
      #1 ena[1] = 0;
      pulses = 0;
      repeat (37) begin
         @(negedge clk);
         pulses += int'(o_stb[1] | o_ls[1] | o_fs[1]);
      end
      chk("hold_pulses1", pulses, 0);
      chk("hold_hpos1", o_h[1], 10);
      chk("hold_vpos1", o_v[1], 3);
      #1 ena[1] = 1;
      wait_at(1, -1, -1, 4, ok);
      chk("resume_hpos1", o_h[1], 11);
      chk("resume_vpos1", o_v[1], 3);

      wait_at(0, 300, -1, 1000, ok);
      #1 rsy[0] = 1;
      @(negedge clk);
      chk("resync_hpos0", o_h[0], 0);
      chk("resync_vpos0", o_v[0], 0);
      chk("resync_fs0", o_fs[0], 1);
      #1 rsy[0] = 0;
      @(negedge clk);
      chk("after_resync_hpos0", o_h[0], 1);

      wait_at(1, 10, 5, 1400, ok);
      #1 rsy[1] = 1;
      @(negedge clk);
      #1 rsy[1] = 0;
      wait_at(1, -1, -1, 4, ok);
      chk("resync_hpos1", o_h[1], 0);
      chk("resync_vpos1", o_v[1], 0);
      chk("resync_fs1", o_fs[1], 1);

      #1 ena[1] = 0;
      rsy[1] = 1;
      @(negedge clk);
      #1 rsy[1] = 0;
      repeat (5) @(negedge clk);
      chk("pend_no_stb1", o_stb[1], 0);
      #1 ena[1] = 1;
      wait_at(1, -1, -1, 4, ok);
      chk("pend_hpos1", o_h[1], 0);
      chk("pend_fs1", o_fs[1], 1);

      wait_at(1, 31, 19, 1400, ok);
      #1 rsy[1] = 1;
      @(negedge clk);
      #1 rsy[1] = 0;
      wait_at(1, -1, -1, 4, ok);
      chk("wrap_resync_hpos1", o_h[1], 0);
      chk("wrap_resync_vpos1", o_v[1], 0);
      chk("wrap_resync_fs1", o_fs[1], 1);
      wait_at(1, -1, -1, 4, ok);
      chk("wrap_next_hpos1", o_h[1], 1);
      chk("wrap_next_fs1", o_fs[1], 0);

      wait_at(1, 24, 13, 1400, ok);
      #1 rst[1] = 1;
      #1;
      chk("async_rst_hpos1", o_h[1], 0);
      chk("async_rst_vpos1", o_v[1], 0);
      chk("async_rst_hsync1", o_hs[1], 1);
      chk("async_rst_vsync1", o_vs[1], 1);
      chk("async_rst_stb1", o_stb[1], 0);
      repeat (2) @(negedge clk);
      #1 rst[1] = 0;
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = o_stb[1] && !o_hs[1];
      end
      chk("post_rst_hsync_hpos1", ok ? int'(o_h[1]) : -1, 23);
      chk("post_rst_hsync_vpos1", o_v[1], 0);

`ifdef VGA_FRAME_CNT_EN
      #1 rst[2] = 1;
      @(negedge clk);
      #1 rst[2] = 0;
      for (int f = 0; f < 3; f++) begin
         ok = 0;
         for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = o_fs[2];
         end
      end
      chk("fcnt_3frames", o_fc[2], 3);
      #1 rsy[2] = 1;
      @(negedge clk);
      chk("fcnt_resync_fs", o_fs[2], 1);
      chk("fcnt_resync", o_fc[2], 4);
      #1 rsy[2] = 0;
`endif

      repeat (4000) begin
         @(negedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            ena[i] = ($urandom_range(0, 99) < 85);
            rsy[i] = ($urandom_range(0, 199) == 0);
            rst[i] = ($urandom_range(0, 999) == 0);
         end
      end
      #1;
      for (int i = 0; i < N; i++) begin
         ena[i] = 1;
         rsy[i] = 0;
         rst[i] = 0;
      end
      repeat (50) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
